// File: rtl/swap_pkg.sv
// rtl/swap_pkg.sv - shared step-select encodings and tracker state type for the swap datapath
package swap_pkg;

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_TMP  = 2'd1;
  localparam logic [1:0] SEL_A    = 2'd2;
  localparam logic [1:0] SEL_B    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/swap_seq_tracker.sv
// rtl/swap_seq_tracker.sv - step-order tracker: busy, done pulse, completed-swap count, error flag
// Optional protocol checking is built only when SWAP_SEQ_CHECK_EN is defined.
module swap_seq_tracker
  import swap_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_w,
  input  logic [1:0]       i_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_swap_cnt,
  output logic             o_err
`ifdef SWAP_SEQ_CHECK_EN
  ,
  input  logic             i_load_drop
`endif
);

  seq_state_e r_state;
  logic       w_step_tmp;
  logic       w_step_a;
  logic       w_step_b;
  logic       w_complete;

  assign w_step_tmp = i_w && (i_sel == SEL_TMP);
  assign w_step_a   = i_w && (i_sel == SEL_A);
  assign w_step_b   = i_w && (i_sel == SEL_B);
  assign w_complete = (r_state == S2) && w_step_b;
  assign o_busy     = (r_state != IDLE);

  // Anything other than the expected next step drops back to IDLE without rollback.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      o_done     <= 1'b0;
      o_swap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE:    r_state <= w_step_tmp ? S1 : IDLE;
        S1:      r_state <= w_step_a ? S2 : IDLE;
        default: r_state <= IDLE;
      endcase
      o_done <= w_complete;
      if (w_complete) begin
        o_swap_cnt <= o_swap_cnt + 1'b1;
      end
    end
  end

`ifdef SWAP_SEQ_CHECK_EN
  logic w_advance;
  logic w_err_evt;
  logic r_err;

  // Every write that is not the expected next step is a violation, as is an idle cycle mid-swap.
  assign w_advance = ((r_state == IDLE) && w_step_tmp) ||
                     ((r_state == S1) && w_step_a) || w_complete;
  assign w_err_evt = (i_w && !w_advance) || (!i_w && o_busy) || i_load_drop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: rtl/swap_datapath.sv
// rtl/swap_datapath.sv - A/B/temp register-swap datapath with operand load mux and step tracker
// Define SWAP_SEQ_CHECK_EN to build the sticky protocol-error checker.
module swap_datapath
  import swap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_load_sel,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_w,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_a_out,
  output logic [WIDTH-1:0] o_b_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_swap_cnt,
  output logic             o_err
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_tmp;
  logic             w_busy;

  // Steps are slaved to w/sel regardless of tracker state; loads only land when fully idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_tmp <= '0;
    end else if (i_w) begin
      case (i_sel)
        SEL_TMP: r_tmp <= r_a;
        SEL_A:   r_a   <= r_b;
        SEL_B:   r_b   <= r_tmp;
        default: ;
      endcase
    end else if (i_load && !w_busy) begin
      if (i_load_sel) begin
        r_b <= i_load_data;
      end else begin
        r_a <= i_load_data;
      end
    end
  end

`ifdef SWAP_SEQ_CHECK_EN
  logic w_load_drop;
  assign w_load_drop = i_load && (i_w || w_busy);
`endif

  swap_seq_tracker #(
    .CNT_W (CNT_W)
  ) u_tracker (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_w         (i_w),
    .i_sel       (i_sel),
    .o_busy      (w_busy),
    .o_done      (o_done),
    .o_swap_cnt  (o_swap_cnt),
    .o_err       (o_err)
`ifdef SWAP_SEQ_CHECK_EN
    ,
    .i_load_drop (w_load_drop)
`endif
  );

  assign o_a_out = r_a;
  assign o_b_out = r_b;
  assign o_busy  = w_busy;

endmodule

// File: tb/tb_swap_datapath.sv
// tb/tb_swap_datapath.sv - self-checking bench: directed vector table, corner sequences, random vs model
module tb_swap_datapath;

`ifdef SWAP_SEQ_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic       lsel = 1'b0;
  logic [7:0] ldata = 8'h00;
  logic       w = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [7:0] a_out, b_out, swap_cnt;
  logic       busy, done, err;
  logic [7:0] a2, b2;
  logic [1:0] cnt2;
  logic       busy2, done2, err2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  swap_datapath #(.WIDTH(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_load(ld), .i_load_sel(lsel), .i_load_data(ldata),
    .i_w(w), .i_sel(sel), .o_a_out(a_out), .o_b_out(b_out), .o_busy(busy),
    .o_done(done), .o_swap_cnt(swap_cnt), .o_err(err)
  );

  swap_datapath #(.WIDTH(8), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_load(ld), .i_load_sel(lsel), .i_load_data(ldata),
    .i_w(w), .i_sel(sel), .o_a_out(a2), .o_b_out(b2), .o_busy(busy2),
    .o_done(done2), .o_swap_cnt(cnt2), .o_err(err2)
  );

  // Reference model: progress counts how many steps of the current exchange have been done.
  int         m_a, m_b, m_t, m_prog, m_cnt;
  bit         m_done, m_err;

  task automatic model_step(input bit r, input bit l, input bit ls, input int ldv,
                            input bit wv, input int sv);
    bit was_busy, adv;
    if (r) begin
      m_a = 0; m_b = 0; m_t = 0; m_prog = 0; m_cnt = 0; m_done = 0; m_err = 0;
      return;
    end
    was_busy = (m_prog != 0);
    adv = wv && (sv == m_prog + 1);
    if (wv) begin
      if (sv == 1) m_t = m_a;
      else if (sv == 2) m_a = m_b;
      else if (sv == 3) m_b = m_t;
    end else if (l && !was_busy) begin
      if (ls) m_b = ldv; else m_a = ldv;
    end
    if (CHECK && ((wv && !adv) || (!wv && was_busy) || (l && (wv || was_busy)))) m_err = 1;
    m_done = adv && (m_prog == 2);
    if (m_done) m_cnt = m_cnt + 1;
    m_prog = adv ? (m_prog + 1) % 3 : 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit ls, input logic [7:0] ldv,
                     input bit wv, input logic [1:0] sv);
    rst = r; ld = l; lsel = ls; ldata = ldv; w = wv; sel = sv;
    model_step(r, l, ls, int'(ldv), wv, int'(sv));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".a"}, 32'(a_out), 32'(m_a));
    chk({tag, ".b"}, 32'(b_out), 32'(m_b));
    chk({tag, ".busy"}, 32'(busy), 32'(m_prog != 0));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".cnt"}, 32'(swap_cnt), 32'(m_cnt % 256));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".a2"}, 32'(a2), 32'(m_a));
    chk({tag, ".b2"}, 32'(b2), 32'(m_b));
    chk({tag, ".busy2"}, 32'(busy2), 32'(m_prog != 0));
    chk({tag, ".done2"}, 32'(done2), 32'(m_done));
    chk({tag, ".cnt2"}, 32'(cnt2), 32'(m_cnt % 4));
    chk({tag, ".err2"}, 32'(err2), 32'(m_err));
  endtask

  typedef struct {
    bit       rst, ld, lsel;
    bit [7:0] ldata;
    bit       w;
    bit [1:0] sel;
    bit [7:0] ea, eb;
    bit       ebusy, edone;
    bit [7:0] ecnt;
    bit       eerr;
  } vec_t;

  function automatic vec_t mk(bit r, bit l, bit ls, bit [7:0] d, bit wv, bit [1:0] s,
                              bit [7:0] ea, bit [7:0] eb, bit eby, bit edn,
                              bit [7:0] ec, bit ee);
    vec_t v;
    v.rst = r; v.ld = l; v.lsel = ls; v.ldata = d; v.w = wv; v.sel = s;
    v.ea = ea; v.eb = eb; v.ebusy = eby; v.edone = edn; v.ecnt = ec; v.eerr = ee;
    return v;
  endfunction

  vec_t vt[37];

  initial begin
    //            rst ld ls data  w sel   A      B    busy done cnt err(check build)
    vt[0]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 8'h12, 0, 0, 8'h12, 8'h00, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 1, 8'h34, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h12, 8'h34, 1, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 8'h00, 1, 2, 8'h34, 8'h34, 1, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 8'h00, 1, 3, 8'h34, 8'h12, 0, 1, 1, 0);
    vt[6]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h34, 8'h12, 0, 0, 1, 0);
    vt[7]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[8]  = mk(0, 1, 0, 8'h12, 0, 0, 8'h12, 8'h00, 0, 0, 0, 0);
    vt[9]  = mk(0, 1, 1, 8'h34, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
    vt[10] = mk(0, 0, 0, 8'h00, 1, 1, 8'h12, 8'h34, 1, 0, 0, 0);
    vt[11] = mk(0, 0, 0, 8'h00, 1, 2, 8'h34, 8'h34, 1, 0, 0, 0);
    vt[12] = mk(0, 0, 0, 8'h00, 1, 3, 8'h34, 8'h12, 0, 1, 1, 0);
    vt[13] = mk(0, 0, 0, 8'h00, 1, 1, 8'h34, 8'h12, 1, 0, 1, 0);
    vt[14] = mk(0, 0, 0, 8'h00, 1, 2, 8'h12, 8'h12, 1, 0, 1, 0);
    vt[15] = mk(0, 0, 0, 8'h00, 1, 3, 8'h12, 8'h34, 0, 1, 2, 0);
    vt[16] = mk(0, 0, 0, 8'h00, 0, 0, 8'h12, 8'h34, 0, 0, 2, 0);
    vt[17] = mk(0, 0, 0, 8'h00, 1, 1, 8'h12, 8'h34, 1, 0, 2, 0);
    vt[18] = mk(0, 1, 0, 8'hFF, 0, 0, 8'h12, 8'h34, 0, 0, 2, 1);
    vt[19] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[20] = mk(0, 1, 0, 8'h12, 0, 0, 8'h12, 8'h00, 0, 0, 0, 0);
    vt[21] = mk(0, 1, 1, 8'h34, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
    vt[22] = mk(0, 0, 0, 8'h00, 1, 1, 8'h12, 8'h34, 1, 0, 0, 0);
    vt[23] = mk(0, 0, 0, 8'h00, 1, 2, 8'h34, 8'h34, 1, 0, 0, 0);
    vt[24] = mk(0, 0, 0, 8'h00, 0, 0, 8'h34, 8'h34, 0, 0, 0, 1);
    vt[25] = mk(0, 0, 0, 8'h00, 0, 0, 8'h34, 8'h34, 0, 0, 0, 1);
    vt[26] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[27] = mk(0, 1, 1, 8'h34, 0, 0, 8'h00, 8'h34, 0, 0, 0, 0);
    vt[28] = mk(0, 0, 0, 8'h00, 1, 3, 8'h00, 8'h00, 0, 0, 0, 1);
    vt[29] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[30] = mk(0, 1, 0, 8'h55, 1, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    vt[31] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[32] = mk(0, 1, 0, 8'h12, 0, 0, 8'h12, 8'h00, 0, 0, 0, 0);
    vt[33] = mk(0, 1, 1, 8'h34, 0, 0, 8'h12, 8'h34, 0, 0, 0, 0);
    vt[34] = mk(0, 0, 0, 8'h00, 1, 1, 8'h12, 8'h34, 1, 0, 0, 0);
    vt[35] = mk(0, 0, 0, 8'h00, 1, 2, 8'h34, 8'h34, 1, 0, 0, 0);
    vt[36] = mk(1, 0, 0, 8'h00, 1, 3, 8'h00, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 37; i++) begin
      cyc(vt[i].rst, vt[i].ld, vt[i].lsel, vt[i].ldata, vt[i].w, vt[i].sel);
      chk($sformatf("vec%0d.a", i), 32'(a_out), 32'(vt[i].ea));
      chk($sformatf("vec%0d.b", i), 32'(b_out), 32'(vt[i].eb));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].ebusy));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'(vt[i].edone));
      chk($sformatf("vec%0d.cnt", i), 32'(swap_cnt), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d.err", i), 32'(err), 32'(vt[i].eerr && CHECK));
    end

    // Counter wrap on the 2-bit instance: 3 then 0 after the fourth swap.
    cyc(1, 0, 0, 8'h00, 0, 0);
    for (int s = 0; s < 4; s++) begin
      cyc(0, 0, 0, 8'h00, 1, 1);
      cyc(0, 0, 0, 8'h00, 1, 2);
      cyc(0, 0, 0, 8'h00, 1, 3);
      if (s == 2) chk("wrap.cnt2_at3", 32'(cnt2), 32'd3);
    end
    chk("wrap.cnt2_at0", 32'(cnt2), 32'd0);
    chk("wrap.cnt8_at4", 32'(swap_cnt), 32'd4);
    chk("wrap.done2", 32'(done2), 32'd1);

    // Randomized traffic biased toward legal step order, checked against the model.
    cyc(1, 0, 0, 8'h00, 0, 0);
    chk_model("rnd_rst");
    for (int n = 0; n < 600; n++) begin
      bit       r, l, ls, wv;
      int       sv;
      r  = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 3) == 0);
      ls = $urandom_range(0, 1) != 0;
      wv = ($urandom_range(0, 9) != 0);
      sv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : m_prog + 1;
      cyc(r, l, ls, 8'($urandom_range(0, 255)), wv, 2'(sv));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
